// File: rtl/bin_enc_if.sv
// Request/result handshake bundle for bin_enc; slave is the encoder's view, master the
// producer/consumer's. Widths follow OUT, with IN = 1 << OUT.
`ifndef HIGH
`define HIGH 1'b1
`endif
`ifndef LOW
`define LOW 1'b0
`endif

interface bin_enc_if #(
  parameter int OUT = 4
) ();
  localparam int IN = 1 << OUT;

  logic [IN-1:0]  in;
  logic           in_valid;
  logic           in_ready;
  logic [OUT-1:0] out;
  logic           out_zero;
  logic           out_valid;
  logic           out_ready;

  modport slave (
    input  in, in_valid, out_ready,
    output in_ready, out, out_zero, out_valid
  );

  modport master (
    output in, in_valid, out_ready,
    input  in_ready, out, out_zero, out_valid
  );
endinterface

// File: rtl/bin_enc.sv
// Binary encoder with a one-entry output register: 1-cycle latency, in_ready = !out_valid || out_ready.
// Build option BIN_ENC_RR_EN selects round-robin grant; otherwise the lowest active index wins.
`ifndef HIGH
`define HIGH 1'b1
`endif

module bin_enc #(
  parameter int   OUT = 4,
  parameter logic ACT = `HIGH,
  parameter int   IN  = 1 << OUT
) (
  input  logic     clk,
  input  logic     reset_,
  bin_enc_if.slave bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t         state_q, state_d;
  logic [OUT-1:0] out_q, out_d;
  logic           zero_q, zero_d;
  logic [IN-1:0]  act_vec;
  logic           any_act;
  logic [OUT-1:0] grant;
  logic           accept;

  assign act_vec       = ACT ? bus.in : ~bus.in;
  assign any_act       = |act_vec;
  assign bus.out_valid = (state_q == FULL);
  assign bus.in_ready  = (state_q == EMPTY) || bus.out_ready;
  assign bus.out       = out_q;
  assign bus.out_zero  = zero_q;
  assign accept        = bus.in_valid && bus.in_ready;

`ifdef BIN_ENC_RR_EN
  logic [OUT-1:0] ptr_q, ptr_d;

  // Scan downward from the farthest offset so the nearest active bit at/after ptr wins;
  // the OUT-bit sum wraps IN-1 back to 0 for free.
  always_comb begin
    logic [OUT-1:0] idx;
    grant = '0;
    idx   = '0;
    for (int k = IN - 1; k >= 0; k--) begin
      idx = ptr_q + OUT'(k);
      if (act_vec[idx]) grant = idx;
    end
  end
`else
  always_comb begin
    grant = '0;
    for (int k = IN - 1; k >= 0; k--) begin
      if (act_vec[k]) grant = OUT'(k);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    zero_d  = zero_q;
`ifdef BIN_ENC_RR_EN
    ptr_d   = ptr_q;
`endif
    if (accept) begin
      state_d = FULL;
      out_d   = any_act ? grant : '0;
      zero_d  = !any_act;
`ifdef BIN_ENC_RR_EN
      if (any_act) ptr_d = grant + OUT'(1);
`endif
    end else if (bus.out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= EMPTY;
      out_q   <= '0;
      zero_q  <= 1'b0;
`ifdef BIN_ENC_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
`ifdef BIN_ENC_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

endmodule

// File: doc/bin_enc.md
BIN_ENC -- requirements
Module: bin_enc

Interface
REQ-001 The block SHALL have parameter OUT, default 4, giving the binary index width.
REQ-002 The block SHALL have parameter ACT, default `HIGH, giving the active level of each request bit.
REQ-003 The block SHALL have parameter IN, default 1 << OUT, giving the request vector width; it is derived and not overridden.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port in, input, IN bits: request vector; bit i is active when it equals ACT.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in holds a request vector to encode.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts in this cycle.
REQ-009 The block SHALL have port out, output, OUT bits: binary index of the granted request bit.
REQ-010 The block SHALL have port out_zero, output, 1 bit: the accepted vector had no active bit.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out and out_zero hold a result.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.

Function
REQ-013 The block SHALL hold a one-entry output register with two states, EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-015 Accept is in_valid && in_ready; on accept the encoded result SHALL appear at the register output with out_valid=1 on the next rising edge (latency 1 cycle).
REQ-016 State transitions SHALL be: EMPTY->FULL on accept; FULL->EMPTY on out_ready without accept; FULL->FULL on out_ready with accept, loading the new result with no bubble.
REQ-017 When out_valid=1 and out_ready=0, out, out_zero and out_valid SHALL hold their values unchanged.
REQ-018 An accepted vector with no active bit SHALL produce out_zero=1 and out=0, and SHALL still complete a transfer.
REQ-019 An accepted vector with at least one active bit SHALL produce out_zero=0 and out equal to the granted index, selected per REQ-024 or REQ-025.
REQ-020 Results SHALL be produced only from accepted vectors; in is ignored when in_valid=0 or in_ready=0.

Reset
REQ-021 While reset_=0, the block SHALL force out_valid=0, out=0, out_zero=0 and the priority pointer to 0, regardless of clk.
REQ-022 Reset asserted mid-operation SHALL discard any held result; after release, in_ready SHALL be 1.
REQ-023 After reset_ is released, the first accept SHALL be honoured on the next rising edge.

Configuration
REQ-024 With macro BIN_ENC_RR_EN defined, the block SHALL use round-robin arbitration:
  - the grant is the lowest-indexed active bit at or above an OUT-bit pointer, wrapping from IN-1 to 0;
  - on each accept with at least one active bit, the pointer becomes (grant+1) mod IN, so grant IN-1 sets it to 0;
  - the pointer is unchanged on a zero-vector accept and when no accept occurs.
REQ-025 Without BIN_ENC_RR_EN, the block SHALL use fixed priority:
  - the grant is the lowest-indexed active bit;
  - no pointer register is implemented.

Verification
REQ-026 Reset check: assert reset_=0 mid-transfer -> out_valid=0, out=0, out_zero=0 and in_ready=1 immediately, with no clock edge needed.
REQ-027 Fixed priority (macro off, OUT=2, ACT=HIGH): in=4'b1010 accepted -> next cycle out=2'd1, out_zero=0, out_valid=1.
REQ-028 Round robin (macro on, OUT=2): in=4'b1111 held, in_valid=1, out_ready=1 -> successive outs 0,1,2,3,0 with one result per cycle and no bubbles.
REQ-029 Backpressure: accept 4'b0010, then hold out_ready=0 and present 4'b0100 -> in_ready=0 and out stays 1; raise out_ready -> out=2 on the next cycle.
REQ-030 Zero vector (macro on, pointer=2): accept 4'b0000 -> out_zero=1 and out=0; then accept 4'b0011 -> out=0 (wrap), confirming the pointer was unchanged.
REQ-031 Active-low (ACT=LOW, macro off): in=4'b1101 -> out=2'd1; in=4'b1111 -> out_zero=1.
